// File: rtl/index_period_meter_pkg.sv
// ---------------------------------------------------------------------------
// index_period_meter_pkg
//
// Shared definitions for the floppy-CPU index period meter:
//   - meter_state_e     : measurement state encoding (IDLE / MEAS / LOCK)
//   - ADDR_*            : byte-wide register window addresses
//   - STAT_*            : bit positions inside the status byte
//   - PERIOD_MAX        : saturation value of the 16-bit period counter
//   - DEBOUNCE_CLKS     : hold time of the optional index glitch filter
//   - pack_status()     : assembles the status byte from its fields
// ---------------------------------------------------------------------------
package index_period_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no index seen, or the last revolution overflowed
        ST_MEAS = 2'd1,   // one index seen, first period still running
        ST_LOCK = 2'd2    // at least one full period captured
    } meter_state_e;

    localparam logic [1:0] ADDR_PERIOD_LO = 2'd0;
    localparam logic [1:0] ADDR_PERIOD_HI = 2'd1;
    localparam logic [1:0] ADDR_STATUS    = 2'd2;

    localparam int STAT_VALID = 0;
    localparam int STAT_OVF   = 1;
    localparam int STAT_IDX   = 2;
    localparam int STAT_LOCK  = 7;

    localparam logic [15:0] PERIOD_MAX = 16'hFFFF;

    // Consecutive clocks the synchronized index must hold a new level
    // before the filtered level follows it.
    localparam int DEBOUNCE_CLKS = 8;

    function automatic logic [7:0] pack_status(input logic lock,
                                               input logic idx,
                                               input logic ovf,
                                               input logic valid);
        logic [7:0] s;
        s             = 8'h00;
        s[STAT_LOCK]  = lock;
        s[STAT_IDX]   = idx;
        s[STAT_OVF]   = ovf;
        s[STAT_VALID] = valid;
        return s;
    endfunction

endpackage

// File: rtl/index_period_meter_index_sync.sv
// ---------------------------------------------------------------------------
// index_sync
//
// Brings the raw, asynchronous, active-low index pulse into the clock
// domain and turns each falling edge into a single-cycle pulse.
//
// Optional feature macro: INDEX_DEBOUNCE_EN
//   When defined, a glitch filter follows the synchronizer: the filtered
//   level only changes once the synchronized input has held the new value
//   for DEBOUNCE_CLKS consecutive clocks. Edge latency grows from 3 to 11.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high
//   index_n    in   raw index input, asynchronous, active-low
//   level      out  index level after sync (and filter), 1 = pulse active
//   idx_edge   out  one-cycle pulse per index pulse (falling edge of index_n)
// ---------------------------------------------------------------------------
module index_sync
    import index_period_meter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic index_n,
    output logic level,
    output logic idx_edge
);

    logic sync1;
    logic sync2;
    logic src;        // active-low level feeding the edge detector
    logic src_prev;

    // Two-flop synchronizer, resets to the inactive (high) level so that
    // leaving reset never fabricates an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= index_n;
            sync2 <= sync1;
        end
    end

`ifdef INDEX_DEBOUNCE_EN
    localparam int RUN_W = $clog2(DEBOUNCE_CLKS);

    logic             filt;
    logic [RUN_W-1:0] run;

    // run counts clocks on which sync2 disagrees with the filtered level;
    // any agreement restarts the count, so only a steady new level passes.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt <= 1'b1;
            run  <= '0;
        end else if (sync2 != filt) begin
            if (run == RUN_W'(DEBOUNCE_CLKS - 1)) begin
                filt <= sync2;
                run  <= '0;
            end else begin
                run <= run + RUN_W'(1);
            end
        end else begin
            run <= '0;
        end
    end

    assign src = filt;
`else
    assign src = sync2;
`endif

    // Registered falling-edge detector: idx_edge is high for exactly one
    // clock, one cycle after src first reads low.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_prev <= 1'b1;
            idx_edge <= 1'b0;
        end else begin
            src_prev <= src;
            idx_edge <= src_prev & ~src;
        end
    end

    assign level = ~src;

endmodule

// File: rtl/index_period_meter.sv
// ---------------------------------------------------------------------------
// index_period_meter
//
// Measures the time between successive floppy index pulses in units of
// 1/TICKHZ seconds and exposes the 16-bit result through a byte-wide
// read-only register window on the floppy CPU I/O bus.
//
// Optional feature macro: INDEX_DEBOUNCE_EN (index glitch filter, see
// index_sync).
//
// Parameters:
//   MCLKFREQ   system clock frequency in Hz
//   TICKHZ     measurement resolution in Hz (MCLKFREQ/TICKHZ must be >= 2)
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high
//   index_n    in   raw drive index pulse, asynchronous, active-low
//   rd         in   single-cycle read strobe
//   addr       in   0 = period lo, 1 = period hi shadow, 2 = status, 3 = 0x00
//   q          out  registered read data, holds while rd = 0
//
// Status byte: {lock, 4'b0, idx, ovf, valid}
// ---------------------------------------------------------------------------
module index_period_meter
    import index_period_meter_pkg::*;
#(
    parameter int MCLKFREQ = 24000000,
    parameter int TICKHZ   = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       index_n,
    input  logic       rd,
    input  logic [1:0] addr,
    output logic [7:0] q
);

    localparam int PRESC_PERIOD = MCLKFREQ / TICKHZ;
    localparam int PRESC_W      = (PRESC_PERIOD > 1) ? $clog2(PRESC_PERIOD) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESC_PERIOD - 1);

    if (PRESC_PERIOD < 2) begin : g_presc_check
        $error("index_period_meter: MCLKFREQ/TICKHZ must be at least 2");
    end

    logic               idx_level;
    logic               idx_edge;
    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic [15:0]        cnt;
    logic               sat;
    logic [15:0]        period;
    logic [7:0]         hi_shadow;
    logic               valid;
    logic               ovf;
    meter_state_e       state;

    index_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .index_n  (index_n),
        .level    (idx_level),
        .idx_edge (idx_edge)
    );

    // ------------------------------------------------------------------
    // Prescaler. tick fires on the clock that carries the down-counter
    // into 0, so after a restart on idx_edge the n-th tick lands exactly
    // n*PRESC_PERIOD clocks later. A capture therefore holds the number
    // of whole tick periods between two edges.
    // ------------------------------------------------------------------
    assign tick = (presc == PRESC_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= PRESC_MAX;
        end else if (idx_edge || presc == '0) begin
            presc <= PRESC_MAX;
        end else begin
            presc <= presc - PRESC_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Period counter: restarts on every edge (edge beats a coincident
    // tick) and sticks at PERIOD_MAX instead of wrapping.
    // ------------------------------------------------------------------
    assign sat = (cnt == PERIOD_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (idx_edge) begin
            cnt <= '0;
        end else if (tick && !sat) begin
            cnt <= cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Measurement FSM and register file. valid and ovf are cleared by
    // reads and set by the FSM; the read side is written first so that a
    // set in the same cycle overrides the clear. q always samples the
    // pre-update values, giving "old data" on any same-cycle collision.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            period    <= '0;
            hi_shadow <= '0;
            valid     <= 1'b0;
            ovf       <= 1'b0;
            q         <= '0;
        end else begin
            if (rd) begin
                case (addr)
                    ADDR_PERIOD_LO: begin
                        q         <= period[7:0];
                        // Freeze the high byte so a lo-then-hi read pair
                        // is coherent even if a capture lands in between.
                        hi_shadow <= period[15:8];
                        valid     <= 1'b0;
                    end
                    ADDR_PERIOD_HI: q <= hi_shadow;
                    ADDR_STATUS: begin
                        q   <= pack_status(state == ST_LOCK, idx_level, ovf, valid);
                        ovf <= 1'b0;
                    end
                    default: q <= 8'h00;
                endcase
            end

            case (state)
                ST_IDLE: begin
                    // Counter keeps running and saturating here; the
                    // first edge only starts a fresh measurement.
                    if (idx_edge) begin
                        state <= ST_MEAS;
                    end
                end
                ST_MEAS, ST_LOCK: begin
                    // A capture of 0xFFFF on the saturating cycle is still
                    // a valid measurement, so the edge is checked first.
                    if (idx_edge) begin
                        period <= cnt;
                        valid  <= 1'b1;
                        state  <= ST_LOCK;
                    end else if (sat) begin
                        ovf   <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_index_period_meter.sv
`timescale 1ns/1ps
module tb_index_period_meter;

    localparam int P  = 10;   // main instance: 1000 Hz / 100 Hz
    localparam int P2 = 2;    // overflow instance: 2000 Hz / 1000 Hz
`ifdef INDEX_DEBOUNCE_EN
    localparam int LAT = 11;
    localparam int W   = 10;
`else
    localparam int LAT = 3;
    localparam int W   = 4;
`endif

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       index_n  = 1'b1;
    logic       rd       = 1'b0;
    logic [1:0] addr     = 2'd0;
    logic [7:0] q;
    logic       index2_n = 1'b1;
    logic       rd2      = 1'b0;
    logic [1:0] addr2    = 2'd0;
    logic [7:0] q2;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    // Reference model of the main instance's programmer-visible state.
    int unsigned m_edges  = 0;     // index edges seen since leaving IDLE
    logic [15:0] m_period = '0;
    logic [7:0]  m_shadow = '0;
    logic        m_valid  = 1'b0;
    logic        m_ovf    = 1'b0;
    int unsigned last_fall = 0;

    index_period_meter #(.MCLKFREQ(1000), .TICKHZ(100)) dut (
        .clk(clk), .reset(reset), .index_n(index_n), .rd(rd), .addr(addr), .q(q));

    index_period_meter #(.MCLKFREQ(2000), .TICKHZ(1000)) dut2 (
        .clk(clk), .reset(reset), .index_n(index2_n), .rd(rd2), .addr(addr2), .q(q2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(10 * 400000);
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (no checking here) ----------------
    task automatic rd_main(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk); rd = 1'b1; addr = a;
        @(negedge clk); rd = 1'b0; d = q;
    endtask

    task automatic rd_aux(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk); rd2 = 1'b1; addr2 = a;
        @(negedge clk); rd2 = 1'b0; d = q2;
    endtask

    task automatic wait_until(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic model_reset();
        m_edges = 0; m_period = '0; m_shadow = '0; m_valid = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic model_read(input logic [1:0] a, input logic idx, output logic [7:0] e);
        case (a)
            2'd0: begin e = m_period[7:0]; m_shadow = m_period[15:8]; m_valid = 1'b0; end
            2'd1: e = m_shadow;
            2'd2: begin e = {(m_edges >= 2), 4'b0000, idx, m_ovf, m_valid}; m_ovf = 1'b0; end
            default: e = 8'h00;
        endcase
    endtask

    // d = clocks between this falling edge of index_n and the previous one
    task automatic model_edge(input int unsigned d);
        int unsigned ticks;
        ticks = d / P;
        if (ticks > 65535) ticks = 65535;
        if (m_edges == 0) m_edges = 1;
        else begin m_period = 16'(ticks); m_valid = 1'b1; m_edges = 2; end
    endtask

    task automatic pulse_at(input int unsigned t, input int w);
        wait_until(t);
        index_n = 1'b0;
        model_edge(cyc - last_fall);
        last_fall = cyc;
        repeat (w) @(negedge clk);
        index_n = 1'b1;
        wait_until(last_fall + w + LAT + 2);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] got, want;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got=%02h want=00", q); end
        checks++; if (q2 !== 8'h00) begin errors++; $display("FAIL reset_q2 got=%02h want=00", q2); end
        for (int a = 3; a >= 0; a--) begin
            rd_main(2'(a), got); model_read(2'(a), 1'b0, want);
            checks++; if (got !== want) begin errors++; $display("FAIL reset_read a=%0d got=%02h want=%02h", a, got, want); end
        end
    endtask

    task automatic test_basic();
        logic [7:0] got, want;
        logic [1:0] seq [3] = '{2'd2, 2'd0, 2'd1};
        pulse_at(cyc + 20, W);
        rd_main(2'd2, got); model_read(2'd2, 1'b0, want);
        checks++; if (got !== want) begin errors++; $display("FAIL basic_meas_status got=%02h want=%02h", got, want); end
        pulse_at(last_fall + 500, W);
        foreach (seq[i]) begin
            rd_main(seq[i], got); model_read(seq[i], 1'b0, want);
            checks++; if (got !== want) begin errors++; $display("FAIL basic_lock a=%0d got=%02h want=%02h", seq[i], got, want); end
        end
        pulse_at(last_fall + 500, W);
        rd_main(2'd2, got); model_read(2'd2, 1'b0, want);
        checks++; if (got !== want) begin errors++; $display("FAIL basic_third_status got=%02h want=%02h", got, want); end
    endtask

    task automatic test_atomic();
        logic [7:0] got, want;
        pulse_at(last_fall + 3000, W);
        rd_main(2'd0, got); model_read(2'd0, 1'b0, want);
        checks++; if (got !== want) begin errors++; $display("FAIL atomic_lo got=%02h want=%02h", got, want); end
        rd_main(2'd1, got); model_read(2'd1, 1'b0, want);
        checks++; if (got !== want) begin errors++; $display("FAIL atomic_hi got=%02h want=%02h", got, want); end
        // lo read, then a capture, then hi read: hi must come from the shadow
        rd_main(2'd0, got); model_read(2'd0, 1'b0, want);
        checks++; if (got !== want) begin errors++; $display("FAIL atomic_lo2 got=%02h want=%02h", got, want); end
        pulse_at(last_fall + 2000, W);
        rd_main(2'd1, got); model_read(2'd1, 1'b0, want);
        checks++; if (got !== want) begin errors++; $display("FAIL atomic_hi_shadow got=%02h want=%02h", got, want); end
        rd_main(2'd0, got); model_read(2'd0, 1'b0, want);
        checks++; if (got !== want) begin errors++; $display("FAIL atomic_lo_new got=%02h want=%02h", got, want); end
        rd_main(2'd1, got); model_read(2'd1, 1'b0, want);
        checks++; if (got !== want) begin errors++; $display("FAIL atomic_hi_new got=%02h want=%02h", got, want); end
    endtask

    task automatic test_edge_tick();
        logic [7:0] got, want;
        // a spacing of 509 puts the edge on the same clock as a tick
        pulse_at(last_fall + 509, W);
        rd_main(2'd0, got); model_read(2'd0, 1'b0, want);
        checks++; if (got !== want) begin errors++; $display("FAIL edge_tick_cap got=%02h want=%02h", got, want); end
        pulse_at(last_fall + 77, W);
        rd_main(2'd0, got); model_read(2'd0, 1'b0, want);
        checks++; if (got !== want) begin errors++; $display("FAIL edge_tick_restart got=%02h want=%02h", got, want); end
    endtask

    task automatic test_capture_read();
        logic [7:0] got, want;
        wait_until(last_fall + 300);
        index_n = 1'b0;
        model_read(2'd0, 1'b0, want);      // the read sees the old period
        model_edge(cyc - last_fall);       // then the capture sets valid
        last_fall = cyc;
        for (int i = 1; i <= LAT + 3; i++) begin
            @(negedge clk);
            if (i == W) index_n = 1'b1;
            if (i == LAT) begin rd = 1'b1; addr = 2'd0; end
            if (i == LAT + 1) begin
                rd = 1'b0; got = q;
                checks++; if (got !== want) begin errors++; $display("FAIL cap_read_lo got=%02h want=%02h", got, want); end
            end
        end
        wait_until(last_fall + W + LAT + 2);
        rd_main(2'd2, got); model_read(2'd2, 1'b0, want);
        checks++; if (got !== want) begin errors++; $display("FAIL cap_read_status got=%02h want=%02h", got, want); end
        rd_main(2'd0, got); model_read(2'd0, 1'b0, want);
        checks++; if (got !== want) begin errors++; $display("FAIL cap_read_new_lo got=%02h want=%02h", got, want); end
    endtask

    task automatic test_idx();
        logic [7:0] got, want;
        wait_until(last_fall + 600);
        index_n = 1'b0;
        model_edge(cyc - last_fall);
        last_fall = cyc;
        wait_until(last_fall + LAT + 2);
        rd_main(2'd2, got); model_read(2'd2, 1'b1, want);
        checks++; if (got !== want) begin errors++; $display("FAIL idx_active got=%02h want=%02h", got, want); end
        wait_until(last_fall + 20);
        index_n = 1'b1;
        wait_until(last_fall + 20 + LAT + 2);
        rd_main(2'd2, got); model_read(2'd2, 1'b0, want);
        checks++; if (got !== want) begin errors++; $display("FAIL idx_released got=%02h want=%02h", got, want); end
    endtask

    task automatic test_random();
        logic [7:0] got, want;
        logic [1:0] a;
        for (int n = 0; n < 12; n++) begin
            pulse_at(last_fall + $urandom_range(60, 2500), W + int'($urandom_range(0, 6)));
            for (int r = 0; r < 3; r++) begin
                a = 2'($urandom_range(0, 3));
                rd_main(a, got); model_read(a, 1'b0, want);
                checks++; if (got !== want) begin errors++; $display("FAIL random n=%0d a=%0d got=%02h want=%02h", n, a, got, want); end
            end
        end
    endtask

`ifdef INDEX_DEBOUNCE_EN
    task automatic test_debounce();
        logic [7:0] got, want;
        rd_main(2'd0, got); model_read(2'd0, 1'b0, want);
        checks++; if (got !== want) begin errors++; $display("FAIL deb_clear got=%02h want=%02h", got, want); end
        wait_until(cyc + 50);
        index_n = 1'b0;                    // 5-clock glitch: must be filtered
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 5) index_n = 1'b1;
            if (i == 3) begin rd = 1'b1; addr = 2'd2; end
            if (i == 4) begin
                rd = 1'b0; got = q; model_read(2'd2, 1'b0, want);
                checks++; if (got !== want) begin errors++; $display("FAIL deb_glitch_idx got=%02h want=%02h", got, want); end
            end
        end
        rd_main(2'd2, got); model_read(2'd2, 1'b0, want);
        checks++; if (got !== want) begin errors++; $display("FAIL deb_no_capture got=%02h want=%02h", got, want); end
    endtask
`endif

    task automatic test_reset_mid();
        logic [7:0] got, want;
        pulse_at(last_fall + 400, W);
        wait_until(cyc + 123);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        model_reset();
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL mid_reset_q got=%02h want=00", q); end
        for (int a = 2; a >= 0; a--) begin
            rd_main(2'(a), got); model_read(2'(a), 1'b0, want);
            checks++; if (got !== want) begin errors++; $display("FAIL mid_reset a=%0d got=%02h want=%02h", a, got, want); end
        end
        pulse_at(cyc + 10, W);
        pulse_at(last_fall + 700, W);
        rd_main(2'd0, got); model_read(2'd0, 1'b0, want);
        checks++; if (got !== want) begin errors++; $display("FAIL mid_reset_resume got=%02h want=%02h", got, want); end
    endtask

    task automatic test_overflow();
        logic [7:0] got;
        int unsigned f1, f2, t_ovf;
        wait_until(cyc + 4);
        index2_n = 1'b0; f1 = cyc;
        repeat (W) @(negedge clk); index2_n = 1'b1;
        wait_until(f1 + 100);
        index2_n = 1'b0; f2 = cyc;          // captures 100/P2 = 50 ticks
        repeat (W) @(negedge clk); index2_n = 1'b1;
        // clock edge on which 65535 ticks have elapsed since the edge
        t_ovf = f2 + LAT + 1 + 65535 * P2;
        wait_until(t_ovf - 300);
        rd_aux(2'd2, got);
        checks++; if (got !== 8'h81) begin errors++; $display("FAIL ovf_before got=%02h want=81", got); end
        wait_until(t_ovf - 2);
        rd_aux(2'd2, got);                  // read lands on the setting edge
        checks++; if (got !== 8'h81) begin errors++; $display("FAIL ovf_same_cycle got=%02h want=81", got); end
        rd_aux(2'd2, got);
        checks++; if (got !== 8'h03) begin errors++; $display("FAIL ovf_set got=%02h want=03", got); end
        rd_aux(2'd2, got);
        checks++; if (got !== 8'h01) begin errors++; $display("FAIL ovf_cleared got=%02h want=01", got); end
        rd_aux(2'd0, got);
        checks++; if (got !== 8'h32) begin errors++; $display("FAIL ovf_period_kept got=%02h want=32", got); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_atomic();
        test_edge_tick();
        test_capture_read();
        test_idx();
        test_random();
`ifdef INDEX_DEBOUNCE_EN
        test_debounce();
`endif
        test_reset_mid();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
